// File: rtl/de2_state_pkg.sv
// Shared register map and FSM encoding for the system-state sequencer.
// Constants only; no timing or flow control.
package de2_state_pkg;

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_STATE   = 2'd1;
  localparam logic [1:0] ADDR_DWELL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int RUN_BIT      = 0;
  localparam int IRQ_EN_BIT   = 1;
  localparam int ONE_SHOT_BIT = 2;

  localparam int PEND_BIT = 1;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/de2_state_sequencer_if.sv
// Avalon-MM slave bus bundle for the sequencer register file.
// Zero-wait-state reads, single-cycle writes; no backpressure.
interface de2_state_sequencer_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/de2_dwell_timer.sv
// Loadable dwell down-counter; zero flag marks the final cycle of a dwell period.
// Load takes effect on the next edge and wins over decrement; no backpressure.
module de2_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] reload_val;

  // A zero dwell behaves as a one-cycle dwell.
  assign reload_val = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign zero       = (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload_val;
    end else if (en && !zero) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

endmodule

// File: rtl/de2_state_sequencer.sv
// Avalon-MM controlled system-state sequencer: steps out_port through 0..NUM_STATES-1.
// Register writes act on the next edge, reads are combinational; no backpressure.
module de2_state_sequencer
  import de2_state_pkg::*;
#(
  parameter int NUM_STATES    = 8,
  parameter int DWELL_W       = 24,
  parameter int DEFAULT_DWELL = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  de2_state_sequencer_if.slave  avs,
  output logic [2:0]            out_port,
  output logic                  irq
);

  localparam logic [2:0] LAST_STATE = 3'(NUM_STATES - 1);

  seq_state_t         fsm;
  logic               irq_en;
  logic               one_shot;
  logic               pend;
  logic [DWELL_W-1:0] dwell;
  logic               t_zero;

  logic wr_en, ctrl_wr, state_wr, dwell_wr, status_wr;
  logic running, start, stop, force_run, advance, finish, t_load, t_en;
  logic unused_wdata;

  assign wr_en     = avs.chipselect && !avs.write_n;
  assign ctrl_wr   = wr_en && (avs.address == ADDR_CONTROL);
  assign state_wr  = wr_en && (avs.address == ADDR_STATE) && (avs.writedata[2:0] <= LAST_STATE);
  assign dwell_wr  = wr_en && (avs.address == ADDR_DWELL);
  assign status_wr = wr_en && (avs.address == ADDR_STATUS);

  assign running   = (fsm == SEQ_RUN);
  assign start     = ctrl_wr && avs.writedata[RUN_BIT] && !running;
  assign stop      = ctrl_wr && !avs.writedata[RUN_BIT] && running;
  assign force_run = state_wr && running;

  // A stop or a forced state on the edge an advance is due cancels that advance.
  assign advance   = running && t_zero && !stop && !state_wr;
  assign finish    = advance && (out_port == LAST_STATE) && one_shot;
  assign t_load    = start || force_run || (advance && !finish);
  assign t_en      = running && !stop;

  assign unused_wdata = ^avs.writedata;

  de2_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (t_load),
    .en      (t_en),
    .dwell   (dwell),
    .zero    (t_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm      <= SEQ_IDLE;
      out_port <= 3'd0;
      irq_en   <= 1'b0;
      one_shot <= 1'b0;
      pend     <= 1'b0;
      dwell    <= DWELL_W'(DEFAULT_DWELL);
    end else begin
      if (ctrl_wr) begin
        irq_en   <= avs.writedata[IRQ_EN_BIT];
        one_shot <= avs.writedata[ONE_SHOT_BIT];
      end
      if (dwell_wr) begin
        dwell <= avs.writedata[DWELL_W-1:0];
      end

      case (fsm)
        SEQ_IDLE: if (start) fsm <= SEQ_RUN;
        SEQ_RUN:  if (stop || finish) fsm <= SEQ_IDLE;
        default:  fsm <= SEQ_IDLE;
      endcase

      if (state_wr) begin
        out_port <= avs.writedata[2:0];
      end else if (advance && !finish) begin
        out_port <= (out_port == LAST_STATE) ? 3'd0 : out_port + 3'd1;
      end

      // Hardware set beats a same-cycle software clear.
      if (advance) begin
        pend <= 1'b1;
      end else if (status_wr && avs.writedata[PEND_BIT]) begin
        pend <= 1'b0;
      end
    end
  end

  assign irq = pend && irq_en;

  always_comb begin
    avs.readdata = 32'd0;
    case (avs.address)
      ADDR_CONTROL: avs.readdata = {29'd0, one_shot, irq_en, running};
      ADDR_STATE:   avs.readdata = {29'd0, out_port};
      ADDR_DWELL:   avs.readdata = 32'(dwell);
      ADDR_STATUS:  avs.readdata = {30'd0, pend, running};
      default:      avs.readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_de2_state_sequencer.sv
// Scoreboard bench for de2_state_sequencer: an 8-state build and a 5-state build.
// Stimulus pushes expectations; a negedge monitor pops and compares them.
module tb_de2_state_sequencer;

  localparam int K_RD  = 0;
  localparam int K_OUT = 1;
  localparam int K_IRQ = 2;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_ST   = 2'd1;
  localparam logic [1:0] A_DW   = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  logic       clk;
  logic       reset_n;
  logic [2:0] out_a, out_b;
  logic       irq_a, irq_b;

  sb_entry_t   sb_q[$];
  sb_entry_t   mon_e;
  logic [31:0] mon_act;
  int          checks;
  int          errors;

  de2_state_sequencer_if bus_a();
  de2_state_sequencer_if bus_b();

  de2_state_sequencer #(.NUM_STATES(8), .DWELL_W(24), .DEFAULT_DWELL(50000)) dut_a (
    .clk(clk), .reset_n(reset_n), .avs(bus_a), .out_port(out_a), .irq(irq_a)
  );

  de2_state_sequencer #(.NUM_STATES(5), .DWELL_W(24), .DEFAULT_DWELL(50000)) dut_b (
    .clk(clk), .reset_n(reset_n), .avs(bus_b), .out_port(out_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.kind)
        K_RD:    mon_act = (mon_e.dut == 0) ? bus_a.readdata : bus_b.readdata;
        K_OUT:   mon_act = {29'd0, (mon_e.dut == 0) ? out_a : out_b};
        default: mon_act = {31'd0, (mon_e.dut == 0) ? irq_a : irq_b};
      endcase
      checks++;
      if (mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int dut, input int kind, input logic [31:0] v, input string n);
    sb_entry_t e;
    e.dut  = dut;
    e.kind = kind;
    e.exp  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic drive(input int dut, input logic [1:0] a, input logic cs, input logic wn,
                       input logic [31:0] d);
    if (dut == 0) begin
      bus_a.address = a; bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.writedata = d;
    end else begin
      bus_b.address = a; bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.writedata = d;
    end
  endtask

  task automatic wr(input int dut, input logic [1:0] a, input logic [31:0] d);
    drive(dut, a, 1'b1, 1'b0, d);
    tick();
    drive(dut, 2'd0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic rd(input int dut, input logic [1:0] a, input logic [31:0] v, input string n);
    drive(dut, a, 1'b1, 1'b1, 32'd0);
    expect_val(dut, K_RD, v, n);
    tick();
    drive(dut, 2'd0, 1'b0, 1'b1, 32'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    drive(0, 2'd0, 1'b0, 1'b1, 32'd0);
    drive(1, 2'd0, 1'b0, 1'b1, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset state and readback
    rd(0, A_CTRL, 32'd0, "reset CONTROL");
    rd(0, A_ST, 32'd0, "reset STATE");
    rd(0, A_DW, 32'd50000, "reset DWELL");
    rd(0, A_STAT, 32'd0, "reset STATUS");
    expect_val(0, K_OUT, 32'd0, "reset out_port");
    expect_val(0, K_IRQ, 32'd0, "reset irq");
    rd(1, A_DW, 32'd50000, "B reset DWELL");
    expect_val(1, K_OUT, 32'd0, "B reset out_port");
    tick();

    // Free-run wrap with 3-cycle dwell
    wr(0, A_DW, 32'd3);
    wr(0, A_CTRL, 32'h1);
    for (int k = 0; k <= 24; k++) begin
      expect_val(0, K_OUT, 32'((k / 3) % 8), $sformatf("wrap out k=%0d", k));
      tick();
    end
    rd(0, A_STAT, 32'h3, "wrap STATUS");
    expect_val(0, K_IRQ, 32'd0, "wrap irq masked");
    wr(0, A_CTRL, 32'h0);
    expect_val(0, K_OUT, 32'd0, "stop on due edge out");
    tick();
    expect_val(0, K_OUT, 32'd0, "stopped out frozen");
    rd(0, A_STAT, 32'h2, "stopped STATUS");
    wr(0, A_STAT, 32'h2);
    rd(0, A_STAT, 32'h0, "pend cleared");

    // One-shot with interrupt, 2-cycle dwell
    wr(0, A_DW, 32'd2);
    wr(0, A_CTRL, 32'h7);
    for (int k = 0; k <= 17; k++) begin
      expect_val(0, K_OUT, 32'(((k / 2) > 7) ? 7 : (k / 2)), $sformatf("oneshot out k=%0d", k));
      expect_val(0, K_IRQ, 32'(k >= 2), $sformatf("oneshot irq k=%0d", k));
      tick();
    end
    rd(0, A_STAT, 32'h2, "oneshot STATUS");
    rd(0, A_CTRL, 32'h6, "oneshot CONTROL");
    expect_val(0, K_IRQ, 32'd1, "oneshot irq held");
    wr(0, A_STAT, 32'h2);
    expect_val(0, K_IRQ, 32'd0, "irq after W1C");
    rd(0, A_STAT, 32'h0, "STATUS after W1C");

    // Forced state on the due edge, 4-cycle dwell
    wr(0, A_ST, 32'd0);
    expect_val(0, K_OUT, 32'd0, "idle force to 0");
    wr(0, A_DW, 32'd4);
    wr(0, A_CTRL, 32'h1);
    for (int k = 0; k <= 3; k++) begin
      expect_val(0, K_OUT, 32'd0, $sformatf("force pre k=%0d", k));
      if (k < 3) tick();
    end
    wr(0, A_ST, 32'd5);
    expect_val(0, K_OUT, 32'd5, "force k=4");
    rd(0, A_STAT, 32'h1, "no pend from force");
    for (int k = 5; k <= 8; k++) begin
      expect_val(0, K_OUT, (k == 8) ? 32'd6 : 32'd5, $sformatf("force hold k=%0d", k));
      if (k < 8) tick();
    end
    wr(0, A_CTRL, 32'h0);

    // NUM_STATES=5 build with zero dwell
    wr(1, A_DW, 32'd0);
    wr(1, A_CTRL, 32'h1);
    for (int k = 0; k <= 6; k++) begin
      expect_val(1, K_OUT, 32'(k % 5), $sformatf("B out k=%0d", k));
      tick();
    end
    wr(1, A_CTRL, 32'h0);
    expect_val(1, K_OUT, 32'd2, "B stopped out");
    wr(1, A_ST, 32'd6);
    expect_val(1, K_OUT, 32'd2, "B STATE=6 ignored");
    rd(1, A_ST, 32'd2, "B STATE readback");
    wr(1, A_ST, 32'd4);
    rd(1, A_ST, 32'd4, "B STATE=4 accepted");

    // Async reset mid-run at state 3
    wr(0, A_ST, 32'd0);
    wr(0, A_DW, 32'd3);
    wr(0, A_CTRL, 32'h3);
    for (int k = 0; k <= 9; k++) begin
      expect_val(0, K_OUT, 32'(k / 3), $sformatf("prereset out k=%0d", k));
      tick();
    end
    expect_val(0, K_IRQ, 32'd1, "prereset irq");
    tick();
    #1;
    reset_n = 1'b0;
    expect_val(0, K_OUT, 32'd0, "reset mid-run out");
    expect_val(0, K_IRQ, 32'd0, "reset mid-run irq");
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      expect_val(0, K_OUT, 32'd0, $sformatf("post-reset out k=%0d", k));
      tick();
    end
    rd(0, A_CTRL, 32'd0, "post-reset CONTROL");
    rd(0, A_STAT, 32'd0, "post-reset STATUS");
    rd(0, A_DW, 32'd50000, "post-reset DWELL");
    expect_val(0, K_OUT, 32'd0, "post-reset out final");
    tick();
    tick();

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/de2_state_sequencer.md
Name: de2_state_sequencer

Overview:
- Avalon-MM slave controller that drives the board's 3-bit system-state output (out_port) autonomously.
- Software sets a dwell time, a run mode and an optional forced state. The block then steps the state value through 0..NUM_STATES-1, holding each state for DWELL clock cycles.
- Raises an interrupt on every hardware-generated state change.
- Sits on the Nios system interconnect beside the other PIO slaves. out_port feeds the board-level state decoder.

Parameters:
- NUM_STATES, 8: number of states in the sequence; legal range 2..8; last state = NUM_STATES-1.
- DWELL_W, 24: width of the dwell reload register and the down-counter.
- DEFAULT_DWELL, 50000: reset value of the DWELL register, in clk cycles.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; asynchronous assert, active-low
- address  input  2  register select: 0 CONTROL, 1 STATE, 2 DWELL, 3 STATUS
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe; a write occurs when chipselect && !write_n
- writedata  input  32  write data
- readdata  output  32  combinational read data, zero wait states; unused bits read 0
- out_port  output  3  current system state
- irq  output  1  level interrupt = pend & irq_en

Behaviour:
- Reset values (reset_n, asynchronous, active-low; clock clk):
  - out_port = 0, run = 0, irq_en = 0, one_shot = 0, pend = 0
  - DWELL = DEFAULT_DWELL, cnt = 0, irq = 0
- Register map:
  - CONTROL [0]: bit0 run, bit1 irq_en, bit2 one_shot; read/write.
  - STATE [1]: bits[2:0]; reads out_port. A write forces out_port = writedata[2:0] if that value is < NUM_STATES. Otherwise the write is ignored.
  - DWELL [2]: bits[DWELL_W-1:0]; read/write.
  - STATUS [3]: bit0 run (read-only), bit1 pend; writing 1 to bit1 clears pend (W1C).
- Effective dwell: deff = (DWELL==0) ? 1 : DWELL.
- States: IDLE (run=0), RUN (run=1).
- IDLE -> RUN: CONTROL write with bit0=1 while run=0. cnt loads deff-1 on the same edge.
- RUN, each clk:
  - cnt != 0: cnt decrements.
  - cnt == 0, out_port < NUM_STATES-1: out_port increments, cnt reloads deff-1, pend sets.
  - cnt == 0, out_port == NUM_STATES-1, one_shot = 0: out_port wraps to 0, cnt reloads, pend sets.
  - cnt == 0, out_port == NUM_STATES-1, one_shot = 1: out_port holds, run clears (-> IDLE), pend sets.
- Timing consequence: each state is held exactly deff cycles. The first advance occurs deff cycles after the run-setting write edge.
- RUN -> IDLE: CONTROL write with bit0=0. out_port and cnt freeze; no pend.
- CONTROL write with bit0=1 while already running: updates irq_en/one_shot only; cnt is not reloaded.
- Forced STATE write while running: out_port loads, cnt reloads deff-1, and any advance due on that edge is suppressed. No pend for forced changes.
- DWELL write: takes effect at the next reload; the in-flight count is unaffected.
- Same-cycle pend set and STATUS W1C: set wins.
- irq is combinational from registered pend and irq_en; it stays high until cleared.
- Reset mid-run: all state returns immediately to the reset values. Sequencing does not resume until run is written again.
- Reads have no side effects.

Decomposition:
- Shared package de2_state_pkg holds:
  - register address constants ADDR_CONTROL/STATE/DWELL/STATUS = 0..3
  - CONTROL bit indices RUN_BIT=0, IRQ_EN_BIT=1, ONE_SHOT_BIT=2
  - STATUS bit index PEND_BIT=1
- One natural sub-module: de2_dwell_timer, the loadable down-counter with load, enable, deff computation and zero flag.
- Register file and FSM stay in the top module.

Test Plan:
- Reset/readback: after reset, read 0..3 -> 0, 0, 50000, 0; out_port=0, irq=0.
- Free-run wrap: DWELL=3, CONTROL=0x1 -> out_port goes 0,1,...,7,0 with exactly 3 cycles per state; pend=1 and irq=0 (irq_en=0).
- One-shot with IRQ: DWELL=2, CONTROL=0x7 -> out_port reaches 7 and holds; STATUS reads 0x2; irq=1. Writing STATUS=0x2 drops irq the next cycle.
- DWELL=0 and NUM_STATES=5 build: run -> state advances every cycle 0..4,0; STATE write of 6 is ignored and out_port is unchanged.
- Forced state mid-run: DWELL=4, run, write STATE=5 on the cycle the advance is due -> out_port=5, held 4 cycles, no pend from the force.
- Async reset mid-run: assert reset_n=0 between clk edges at state 3 -> out_port=0 and irq=0 immediately; after release, out_port stays 0 until run is written.
